ysyx_041461_pipe_stage_reg: RTL

Parametrised pipeline stage register for the ysyx_041461 core, the successor to the fixed per-stage registers (IF/ID/EXE/MEM/WB). It carries an opaque payload of DATA_W bits using a valid/ready handshake instead of a global enable. It supports kill (bubble insertion) and flush, and has an optional 2-entry skid buffer that breaks the combinational ready path. The core instantiates one per stage boundary, with the payload being the concatenation of that stage's fields.

---
 rtl/ysyx_041461_pipe_pkg.sv | 31 +++
 rtl/ysyx_041461_sat_counter.sv | 22 ++
 rtl/ysyx_041461_pipe_stage_reg.sv | 118 +++++++++++
 3 files changed

// File: rtl/ysyx_041461_pipe_pkg.sv
// Shared constants for the ysyx_041461 stage-boundary registers: payload field
// layout, per-stage payload widths and the architectural reset PC.
package ysyx_041461_pipe_pkg;

    localparam int OCC_W    = 2;
    localparam int TRAP_W   = 1;
    localparam int PC_W     = 32;
    localparam int RD_W     = 5;
    localparam int CTRL_W   = 16;

    localparam int TRAP_OFF = 0;
    localparam int PC_OFF   = TRAP_OFF + TRAP_W;
    localparam int RD_OFF   = PC_OFF + PC_W;
    localparam int CTRL_OFF = RD_OFF + RD_W;

    localparam int IF_ID_W   = TRAP_W + PC_W + 32;
    localparam int ID_EXE_W  = CTRL_OFF + CTRL_W + 64;
    localparam int EXE_MEM_W = CTRL_OFF + CTRL_W + 64;
    localparam int MEM_WB_W  = CTRL_OFF + CTRL_W + 64;

    localparam logic [PC_W-1:0] PC_RST = 32'h8000_0000;

    // Reset payload for a 64-bit stage: PC field at its reset vector, all else 0.
    function automatic logic [63:0] pc_rst_payload64();
        logic [63:0] p;
        p = '0;
        p[PC_OFF +: PC_W] = PC_RST;
        return p;
    endfunction

endpackage

// File: rtl/ysyx_041461_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ysyx_041461_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_041461_pipe_stage_reg.sv
// Valid/ready pipeline stage register with kill, flush, optional 2-entry skid
// buffer and a saturating stall-cycle counter.
module ysyx_041461_pipe_stage_reg
    import ysyx_041461_pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                SKID     = 1,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_kill,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Handshake: a beat moves on a rising edge where valid & ready are both high;
    // a producer may not retract data while valid & ~ready. A killed beat is
    // consumed on in_ready but never stored.
    logic in_fire;
    logic main_free;
    logic skid_valid;

    assign in_fire   = in_valid & ~in_kill & in_ready;
    assign main_free = ~out_valid | out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid_q;
            logic [DATA_W-1:0] skid_data;

            // in_ready comes straight from a flop: no path from out_ready.
            assign in_ready   = ~skid_valid_q;
            assign skid_valid = skid_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid    <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else if (flush) begin
                    out_valid    <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else if (main_free) begin
                    if (skid_valid_q) begin
                        out_valid    <= 1'b1;
                        skid_valid_q <= in_fire;
                    end else begin
                        out_valid    <= in_fire;
                    end
                end else if (in_fire) begin
                    skid_valid_q <= 1'b1;
                end
            end

            // Payloads only load on a real transfer so they stay quiet in stalls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_data  <= RST_DATA;
                    skid_data <= RST_DATA;
                end else if (!flush) begin
                    if (main_free) begin
                        if (skid_valid_q) begin
                            out_data <= skid_data;
                            if (in_fire) skid_data <= in_data;
                        end else if (in_fire) begin
                            out_data <= in_data;
                        end
                    end else if (in_fire) begin
                        skid_data <= in_data;
                    end
                end
            end
        end else begin : g_noskid
            assign in_ready   = ~out_valid | out_ready;
            assign skid_valid = 1'b0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= in_fire | (out_valid & ~out_ready);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_data <= RST_DATA;
                end else if (!flush && in_fire) begin
                    out_data <= in_data;
                end
            end
        end
    endgenerate

    assign occupancy = OCC_W'(out_valid) + OCC_W'(skid_valid);

    ysyx_041461_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_valid & ~out_ready),
        .clr(stall_clr),
        .cnt(stall_cnt)
    );

endmodule
